// File: rtl/prbs7_checker.sv
// Purpose: PRBS7 (x^7+x^6+1) receive checker with hunt/verify/lock acquisition and windowed loss-of-lock.
// Latency: one cycle; a bit sampled on edge N shows up in the registered outputs right after edge N.
// Backpressure: none; din_valid=0 edges are idle (all state held, err_pulse low).
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-high reset
//   din        - received serial bit
//   din_valid  - din is sampled only when high
//   clear_cnt  - synchronous clear of err_count (a same-edge error still counts)
//   locked     - high while in LOCKED
//   err_pulse  - one-cycle flag for a mismatched bit while LOCKED
//   err_count  - saturating count of errors seen while LOCKED
//   state      - HUNT=0, VERIFY=1, LOCKED=2
module prbs7_checker #(
   parameter int SYNC_LEN  = 16,
   parameter int WIN_LEN   = 64,
   parameter int LOSS_ERRS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        din,
   input  logic        din_valid,
   input  logic        clear_cnt,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic [1:0]  state
);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam int FILL_W  = $clog2(7 + 1);
   localparam int MATCH_W = $clog2(SYNC_LEN + 1);
   localparam int WBITS_W = $clog2(WIN_LEN + 1);
   localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

   localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(6);
   localparam logic [MATCH_W-1:0] SYNC_CNT  = MATCH_W'(SYNC_LEN);
   localparam logic [WBITS_W-1:0] WIN_CNT   = WBITS_W'(WIN_LEN);
   localparam logic [WERR_W-1:0]  LOSS_CNT  = WERR_W'(LOSS_ERRS);

   logic [1:0]         state_q,     state_d;
   logic [6:0]         s_q,         s_d;
   logic [FILL_W-1:0]  fill_cnt_q,  fill_cnt_d;
   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic [WBITS_W-1:0] win_bits_q,  win_bits_d;
   logic [WERR_W-1:0]  win_err_q,   win_err_d;
   logic [15:0]        err_count_q, err_count_d;
   logic               err_pulse_q, err_pulse_d;
   logic               locked_q,    locked_d;

   logic               exp_bit;
   logic               mismatch;
   logic [6:0]         s_shift;
   logic [15:0]        err_base;
   logic [WBITS_W-1:0] win_bits_inc;
   logic [WERR_W-1:0]  win_err_inc;

   assign exp_bit  = s_q[6] ^ s_q[5];
   assign mismatch = (din != exp_bit);
   assign s_shift  = {s_q[5:0], din};

   // clear_cnt acts first so that a same-edge error lands on zero and yields 1.
   assign err_base = clear_cnt ? 16'd0 : err_count_q;

   assign win_bits_inc = win_bits_q + WBITS_W'(1);
   assign win_err_inc  = mismatch ? (win_err_q + WERR_W'(1)) : win_err_q;

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      fill_cnt_d  = fill_cnt_q;
      match_cnt_d = match_cnt_q;
      win_bits_d  = win_bits_q;
      win_err_d   = win_err_q;
      err_count_d = err_base;
      err_pulse_d = 1'b0;

      if (din_valid) begin
         case (state_q)
            ST_HUNT: begin
               s_d = s_shift;
               if (fill_cnt_q == FILL_LAST) begin
                  fill_cnt_d = '0;
                  // An all-zero register is the PRBS lock-up state; keep hunting.
                  if (s_shift != 7'h00) begin
                     state_d     = ST_VERIFY;
                     match_cnt_d = '0;
                  end
               end else begin
                  fill_cnt_d = fill_cnt_q + FILL_W'(1);
               end
            end

            ST_VERIFY: begin
               if (!mismatch) begin
                  s_d         = {s_q[5:0], exp_bit};
                  match_cnt_d = match_cnt_q + MATCH_W'(1);
                  if (match_cnt_d == SYNC_CNT) begin
                     state_d     = ST_LOCKED;
                     match_cnt_d = '0;
                     win_bits_d  = '0;
                     win_err_d   = '0;
                  end
               end else begin
                  // Acquisition failures are not counted as errors.
                  state_d     = ST_HUNT;
                  fill_cnt_d  = '0;
                  match_cnt_d = '0;
               end
            end

            ST_LOCKED: begin
               // Free-run on the expected sequence so errors never re-seed the register.
               s_d = {s_q[5:0], exp_bit};
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  err_count_d = (err_base == 16'hFFFF) ? 16'hFFFF : (err_base + 16'd1);
               end
               // Loss takes priority over the window rolling over on the same bit.
               if (win_err_inc == LOSS_CNT) begin
                  state_d    = ST_HUNT;
                  fill_cnt_d = '0;
                  win_bits_d = '0;
                  win_err_d  = '0;
               end else if (win_bits_inc == WIN_CNT) begin
                  win_bits_d = '0;
                  win_err_d  = '0;
               end else begin
                  win_bits_d = win_bits_inc;
                  win_err_d  = win_err_inc;
               end
            end

            default: begin
               state_d    = ST_HUNT;
               fill_cnt_d = '0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_HUNT;
         s_q         <= 7'h00;
         fill_cnt_q  <= '0;
         match_cnt_q <= '0;
         win_bits_q  <= '0;
         win_err_q   <= '0;
         err_count_q <= 16'd0;
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         fill_cnt_q  <= fill_cnt_d;
         match_cnt_q <= match_cnt_d;
         win_bits_q  <= win_bits_d;
         win_err_q   <= win_err_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= locked_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign state     = state_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Purpose: self-checking bench for prbs7_checker against a sequence-level reference model.
// Latency: model predicts the outputs visible just after each rising edge.
// Backpressure: not applicable; stimulus includes din_valid gaps.
module tb_prbs7_checker;

   localparam int SYNC_LEN  = 16;
   localparam int WIN_LEN   = 64;
   localparam int LOSS_ERRS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        din;
   logic        din_valid;
   logic        clear_cnt;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [1:0]  state;

   prbs7_checker #(
      .SYNC_LEN (SYNC_LEN),
      .WIN_LEN  (WIN_LEN),
      .LOSS_ERRS(LOSS_ERRS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .din      (din),
      .din_valid(din_valid),
      .clear_cnt(clear_cnt),
      .locked   (locked),
      .err_pulse(err_pulse),
      .err_count(err_count),
      .state    (state)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: phase, counters, and the recent reference-bit history.
   int   m_st;
   int   m_fill;
   int   m_match;
   int   m_wb;
   int   m_we;
   int   m_cnt;
   bit   m_pulse;
   bit   hist[$];

   // Stimulus PRBS7 generator state.
   logic [6:0] g;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st    = 0;
      m_fill  = 0;
      m_match = 0;
      m_wb    = 0;
      m_we    = 0;
      m_cnt   = 0;
      m_pulse = 1'b0;
      hist.delete();
   endtask

   task automatic model_update(input bit d, input bit v, input bit clr);
      bit e;
      int ones;
      m_pulse = 1'b0;
      if (clr) m_cnt = 0;
      if (!v) return;
      if (m_st == 0) begin
         hist.push_back(d);
         m_fill++;
         if (m_fill == 7) begin
            m_fill = 0;
            ones = 0;
            foreach (hist[i]) ones += int'(hist[i]);
            if (ones == 0) hist.delete();
            else begin
               m_st    = 1;
               m_match = 0;
            end
         end
      end else begin
         // Next reference bit is the XOR of the bits 7 and 6 positions back.
         e = hist[0] ^ hist[1];
         hist.push_back(e);
         void'(hist.pop_front());
         if (m_st == 1) begin
            if (d == e) begin
               m_match++;
               if (m_match == SYNC_LEN) begin
                  m_st  = 2;
                  m_wb  = 0;
                  m_we  = 0;
                  m_match = 0;
               end
            end else begin
               m_st   = 0;
               m_fill = 0;
               m_match = 0;
               hist.delete();
            end
         end else begin
            m_wb++;
            if (d != e) begin
               m_pulse = 1'b1;
               m_we++;
               if (m_cnt < 65535) m_cnt++;
            end
            if (m_we == LOSS_ERRS) begin
               m_st   = 0;
               m_fill = 0;
               m_wb   = 0;
               m_we   = 0;
               hist.delete();
            end else if (m_wb == WIN_LEN) begin
               m_wb = 0;
               m_we = 0;
            end
         end
      end
   endtask

   // Single compare process: every edge, DUT outputs against the model.
   always @(posedge clk) begin
      #1;
      chk("state",     32'(state),     32'(m_st));
      chk("locked",    32'(locked),    32'(m_st == 2));
      chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
      chk("err_count", 32'(err_count), 32'(m_cnt));
   end

   task automatic step(input bit d, input bit v, input bit clr);
      @(negedge clk);
      din       = d;
      din_valid = v;
      clear_cnt = clr;
      model_update(d, v, clr);
      @(posedge clk);
      #2;
   endtask

   // Send the next generator bit (optionally inverted); invalid slots carry junk.
   task automatic send(input bit flip, input bit v, input bit clr);
      bit b;
      if (v) begin
         b = g[6] ^ g[5];
         g = {g[5:0], b};
         b = b ^ flip;
      end else begin
         b = 1'($urandom);
      end
      step(b, v, clr);
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 1'b1, 1'b0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset     = 1'b1;
      din_valid = 1'b0;
      clear_cnt = 1'b0;
      model_reset();
      g = 7'h7F;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      din       = 1'b0;
      din_valid = 1'b0;
      clear_cnt = 1'b0;
      g         = 7'h7F;
      model_reset();

      // Reset state and clean lock timing.
      reset_dut();
      chk("rst_state",  32'(state),     32'd0);
      chk("rst_locked", 32'(locked),    32'd0);
      chk("rst_count",  32'(err_count), 32'd0);
      clean(22);
      chk("pre_lock_state",  32'(state),  32'd1);
      chk("pre_lock_locked", 32'(locked), 32'd0);
      clean(1);
      chk("lock_at_23", 32'(locked), 32'd1);
      chk("lock_state", 32'(state),  32'd2);
      clean(500);
      chk("clean_count", 32'(err_count), 32'd0);

      // Single error.
      send(1'b1, 1'b1, 1'b0);
      chk("single_pulse", 32'(err_pulse), 32'd1);
      chk("single_count", 32'(err_count), 32'd1);
      send(1'b0, 1'b1, 1'b0);
      chk("single_pulse_drop", 32'(err_pulse), 32'd0);
      chk("single_locked",     32'(locked),    32'd1);

      // clear_cnt alone, then together with an error.
      send(1'b0, 1'b1, 1'b1);
      chk("clear_only", 32'(err_count), 32'd0);
      send(1'b1, 1'b1, 1'b1);
      chk("clear_with_err", 32'(err_count), 32'd1);
      chk("clear_keeps_lock", 32'(locked), 32'd1);

      // Loss of lock on the 8th error in one window.
      reset_dut();
      clean(23);
      for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 1'b0);
      chk("loss_7_state", 32'(state), 32'd2);
      send(1'b1, 1'b1, 1'b0);
      chk("loss_8_state", 32'(state),     32'd0);
      chk("loss_8_count", 32'(err_count), 32'd8);
      chk("loss_8_pulse", 32'(err_pulse), 32'd1);
      clean(40);

      // Window rollover: 7 errors per window never loses lock; 8 in the second does.
      reset_dut();
      clean(23);
      for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 1'b0);
      clean(57);
      for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 1'b0);
      chk("win_roll_locked", 32'(locked),    32'd1);
      chk("win_roll_count",  32'(err_count), 32'd14);
      send(1'b1, 1'b1, 1'b0);
      chk("win2_loss_state", 32'(state),     32'd0);
      chk("win2_loss_count", 32'(err_count), 32'd15);

      // Alternating valid: 23 valid bits over 45 cycles.
      reset_dut();
      for (int i = 0; i < 44; i++) send(1'b0, (i % 2) == 0, 1'b0);
      chk("gap_pre_lock", 32'(locked), 32'd0);
      send(1'b0, 1'b1, 1'b0);
      chk("gap_lock_45", 32'(locked), 32'd1);
      for (int i = 0; i < 100; i++) send(1'b0, (i % 2) == 1, 1'b0);
      chk("gap_no_err", 32'(err_count), 32'd0);

      // All-zero input never leaves HUNT.
      reset_dut();
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
      chk("zeros_hunt", 32'(state), 32'd0);

      // Error on the 10th VERIFY bit returns to HUNT without counting.
      reset_dut();
      clean(7 + 9);
      chk("verify9_state", 32'(state), 32'd1);
      send(1'b1, 1'b1, 1'b0);
      chk("verify_err_state", 32'(state),     32'd0);
      chk("verify_err_count", 32'(err_count), 32'd0);
      chk("verify_err_pulse", 32'(err_pulse), 32'd0);
      clean(23);
      chk("verify_relock", 32'(locked), 32'd1);

      // Five spread errors, then an asynchronous reset between edges.
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 1'b1, 1'b0);
         clean(5);
      end
      chk("pre_async_count", 32'(err_count), 32'd5);
      @(negedge clk);
      #1;
      reset     = 1'b1;
      din_valid = 1'b0;
      model_reset();
      #1;
      chk("async_locked", 32'(locked),    32'd0);
      chk("async_count",  32'(err_count), 32'd0);
      chk("async_state",  32'(state),     32'd0);
      #1;
      reset = 1'b0;
      clean(22);
      chk("async_pre_relock", 32'(locked), 32'd0);
      clean(1);
      chk("async_relock", 32'(locked), 32'd1);
      clean(10);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
